multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Control FSM for the multicycle RV32I datapath. It is the driving end of the ALU interface: each cycle it issues the ALU operation code (team ALU control macros: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LESS, ALU_SLL, ALU_SRL, ALU_SRA) and the operand selects. It consumes the ALU Zero flag. It also sequences fetch, memory, writeback and branch steps, with a memory-ready handshake, illegal-instruction trap and retired-instruction counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
op  in  7  instruction opcode (IR[6:0])
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
Zero  in  1  ALU zero flag
MemRdy  in  1  memory completes access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction/OldPC register enable
RegWrite  out  1  register file write
ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ALU result
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero
ALUSrcB  out  2  00=RD2, 01=imm, 10=constant 4
ALUControl  out  4  ALU operation code
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
Illegal  out  1  sticky illegal-instruction flag
RetireCnt  out  RETIRE_W  retired instruction count

Behaviour:
- Reset: rising clk with rst_n=0 -> state FETCH, RetireCnt=0, Illegal=0. Applies mid-instruction and in TRAP. While rst_n=0, PCWrite/IRWrite/RegWrite/MemWrite are forced 0.
- ImmSrc: combinational from op. lw/I-type->000, sw->001, branch->010, jal->011, lui->100, else 000.
- Legal opcodes: 0000011 lw (funct3 010 only), 0100011 sw (funct3 010 only), 0110011 R, 0010011 I-ALU, 1100011 branch (funct3 000 beq, 001 bne only), 1101111 jal, 0110111 lui.
- R-type funct3 map: 000 ADD, or SUB if funct7b5. 001 SLL. 011 LESS (unsigned compare). 100 XOR. 101 SRL, or SRA if funct7b5. 110 OR. 111 AND. 010 (slt) is illegal.
- I-type funct3 map: same as R-type, except 000 is always ADD. 010 is illegal.
- Unlisted combinations are illegal and are detected in DECODE.
- Unlisted outputs are 0 in a state; ALUControl defaults to ADD.
- States and transitions:
  FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=MemRdy. Stays in FETCH while MemRdy=0; goes to DECODE on MemRdy=1.
  DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch target into ALUOut). Next state by op: lw/sw->MEMADR, R->EXECR, I->EXECI, branch->BRANCH, jal->JAL, lui->LUI, illegal->TRAP.
  MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. lw->MEMREAD, sw->MEMWRITE.
  MEMREAD: AdrSrc=1. Holds until MemRdy, then MEMWB.
  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  MEMWRITE: AdrSrc=1, MemWrite=1 held until MemRdy=1 -> FETCH.
  EXECR: ALUSrcA=10, ALUSrcB=00, decoded op -> ALUWB.
  EXECI: ALUSrcA=10, ALUSrcB=01, decoded op -> ALUWB.
  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. PCWrite=Zero for beq, ~Zero for bne -> FETCH.
  JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1 -> ALUWB.
  LUI: ALUSrcA=11, ALUSrcB=01, ADD -> ALUWB.
  TRAP: all enables 0, Illegal=1. Remains in TRAP until reset.
- RetireCnt increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps 2^RETIRE_W-1 -> 0. It does not increment while stalled or in TRAP.
- Latency with MemRdy always 1: lw 5 cycles; sw 4; R/I 4; branch 3; jal 4; lui 4.

Test Plan:
- add (op 0110011, f3 000, f7b5 0), MemRdy=1 -> states FETCH, DECODE, EXECR, ALUWB. EXECR ALUControl=ALU_ADD, ALUSrcB=00. ALUWB RegWrite=1. RetireCnt 0->1.
- sra / sub / sltu / srai: R f3 101 f7b5 1 -> ALU_SRA; R f3 000 f7b5 1 -> ALU_SUB; R f3 011 -> ALU_LESS; I f3 101 f7b5 1 -> ALU_SRA. I f3 000 f7b5 1 -> ALU_ADD.
- beq with Zero=1 -> PCWrite=1 in BRANCH. bne with Zero=1 -> PCWrite=0. Both ALUControl=ALU_SUB and 3-cycle latency.
- lw with MemRdy low 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite only on the MemRdy cycle. Total 10 cycles. RegWrite once with ResultSrc=01.
- op 0000000, then slt (R f3 010) after reset -> TRAP, Illegal=1, all enables 0 for 20 cycles. rst_n=0 one cycle -> FETCH, Illegal=0, RetireCnt=0.
- Reset asserted in MEMWRITE with MemRdy=0 -> MemWrite=0 the same cycle, FETCH next, no increment. RetireCnt preset to 2^32-1 by 2^32-1 retirements (or forced) wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Shared ALU/opcode constants and the controller <-> datapath interface for the
// multicycle RV32I core. The controller is the master end.
package multicycle_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_LESS = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

endpackage

interface multicycle_ctrl_if #(
  parameter int RETIRE_W = 32
);

  logic [6:0]          op;
  logic [2:0]          funct3;
  logic                funct7b5;
  logic                Zero;
  logic                MemRdy;
  logic                PCWrite;
  logic                AdrSrc;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegWrite;
  logic [1:0]          ResultSrc;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [3:0]          ALUControl;
  logic [2:0]          ImmSrc;
  logic                Illegal;
  logic [RETIRE_W-1:0] RetireCnt;

  modport master (
    input  op, funct3, funct7b5, Zero, MemRdy,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, RetireCnt
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemRdy,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, RetireCnt
  );

endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute,
// drives ALU op and operand selects, traps illegal instructions, counts retirements.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          alu_dec;
  logic                f3_ok;
  logic                legal;
  logic                retire;
  logic [RETIRE_W-1:0] retire_cnt;

  // funct3 -> ALU op shared by R and I forms; only R-type turns 000 into SUB.
  always_comb begin
    alu_dec = ALU_ADD;
    f3_ok   = 1'b1;
    case (bus.funct3)
      3'b000:  alu_dec = (bus.funct7b5 && bus.op == OP_R) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  f3_ok   = 1'b0;
      3'b011:  alu_dec = ALU_LESS;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_LW, OP_SW:   legal = (bus.funct3 == 3'b010);
      OP_R, OP_I:     legal = f3_ok;
      OP_BR:          legal = (bus.funct3[2:1] == 2'b00);
      OP_JAL, OP_LUI: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 3'b001;
      OP_BR:   bus.ImmSrc = 3'b010;
      OP_JAL:  bus.ImmSrc = 3'b011;
      OP_LUI:  bus.ImmSrc = 3'b100;
      default: bus.ImmSrc = 3'b000;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;

    case (state)
      S_FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemRdy;
        bus.PCWrite   = bus.MemRdy;
        if (bus.MemRdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        if (!legal) state_nxt = S_TRAP;
        else begin
          case (bus.op)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_R:         state_nxt = S_EXECR;
            OP_I:         state_nxt = S_EXECI;
            OP_BR:        state_nxt = S_BRANCH;
            OP_JAL:       state_nxt = S_JAL;
            OP_LUI:       state_nxt = S_LUI;
            default:      state_nxt = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_nxt   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.MemRdy) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.MemRdy) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_dec;
        state_nxt      = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec;
        state_nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] distinguishes bne from beq; both compare via SUB.
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = bus.funct3[0] ? ~bus.Zero : bus.Zero;
        state_nxt      = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_nxt   = S_ALUWB;
      end
      S_LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        state_nxt   = S_ALUWB;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase

    retire = (state_nxt == S_FETCH) &&
             (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BRANCH);

    // Architectural side effects are suppressed for the whole reset cycle.
    if (!rst_n) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  assign bus.Illegal   = (state == S_TRAP);
  assign bus.RetireCnt = retire_cnt;

endmodule
